// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: BRAM with output register, fixed 3-cycle read latency, optional xFFFF switch/hex I/O.
// Optional I/O mapping at xFFFF is enabled by defining SLC3_MEM_MMIO_EN.
module slc3_mem_responder #(
    parameter int          ADDR_W    = 10,
    parameter logic [15:0] HEX_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_ena,
    input  logic        mem_wr_ena,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        err,
    input  logic [15:0] sw_i,
    output logic [15:0] hex_o
);

    typedef enum logic [1:0] {IDLE, ACC1, DATA, HOLD} state_t;

    state_t             state, state_nxt;
    logic               err_set;
    logic               accept;
    logic               is_io;
    logic               wr_q;
    logic               io_q;
    logic [15:0]        bram_q;
    logic [15:0]        out_q;
    logic [15:0]        last_q;
    logic [15:0]        sw_sync;
    logic [ADDR_W-1:0]  idx;
    logic [15:0]        mem [0:(1<<ADDR_W)-1];

    assign idx    = addr[ADDR_W-1:0];
    assign accept = (state == IDLE) && mem_ena;

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        case (state)
            IDLE: if (mem_ena) state_nxt = ACC1;
            ACC1: begin
                if (mem_ena) begin
                    state_nxt = DATA;
                end else begin
                    state_nxt = IDLE;
                    err_set   = 1'b1;
                end
            end
            DATA: begin
                if (mem_ena) begin
                    state_nxt = HOLD;
                end else begin
                    state_nxt = IDLE;
                    err_set   = 1'b1;
                end
            end
            HOLD: if (!mem_ena) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            err    <= 1'b0;
            wr_q   <= 1'b0;
            io_q   <= 1'b0;
            out_q  <= 16'h0000;
            last_q <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (err_set) err <= 1'b1;
            if (accept) begin
                wr_q <= mem_wr_ena;
                io_q <= is_io;
            end
            // Output register stage: loads only when the access proceeds to DATA.
            if (state == ACC1 && mem_ena && !wr_q)
                out_q <= io_q ? sw_sync : bram_q;
            if (rdata_valid)
                last_q <= out_q;
        end
    end

    // Block RAM: contents and read latch are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept && !reset && !is_io) begin
            if (mem_wr_ena)
                mem[idx] <= wdata;
            else
                bram_q <= mem[idx];
        end
    end

    // An access whose strobe drops in DATA is not a completed read.
    assign rdata_valid = (state == DATA) && mem_ena && !wr_q;
    assign rdata       = rdata_valid ? out_q : last_q;
    assign busy        = (state != IDLE);

`ifdef SLC3_MEM_MMIO_EN
    logic [15:0] sw_s1;
    logic [15:0] hex_q;

    assign is_io = (addr == 16'hFFFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1   <= 16'h0000;
            sw_sync <= 16'h0000;
            hex_q   <= HEX_RESET;
        end else begin
            sw_s1   <= sw_i;
            sw_sync <= sw_s1;
            if (accept && is_io && mem_wr_ena)
                hex_q <= wdata;
        end
    end

    assign hex_o = hex_q;
`else
    logic unused_inputs;

    assign is_io         = 1'b0;
    assign sw_sync       = 16'h0000;
    assign hex_o         = HEX_RESET;
    assign unused_inputs = ^{sw_i, addr[15:ADDR_W]};
`endif

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Bench for slc3_mem_responder: directed and random accesses checked against an associative-array memory model.
module tb_slc3_mem_responder;

    localparam logic [15:0] HEX_RST = 16'hA5A5;
`ifdef SLC3_MEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        mem_ena;
    logic        mem_wr_ena;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic        err;
    logic [15:0] sw_i;
    logic [15:0] hex_o;

    slc3_mem_responder #(.ADDR_W(10), .HEX_RESET(HEX_RST)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_ena     (mem_ena),
        .mem_wr_ena  (mem_wr_ena),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .busy        (busy),
        .err         (err),
        .sw_i        (sw_i),
        .hex_o       (hex_o)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] model_mem [int];
    logic [15:0] last_rd;
    logic [15:0] hex_m;
    bit          err_m;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access with the strobe high for n cycles, followed by low cycles up to 4 total.
    task automatic access(input logic [15:0] a, input bit wr, input logic [15:0] wd, input int n);
        bit          io;
        bit          valid_exp;
        bit          busy_exp;
        bit          err_exp;
        int          idx;
        int          busy_end;
        logic [15:0] rd_val;
        io       = MMIO && (a == 16'hFFFF);
        idx      = int'(a & 16'h03FF);
        rd_val   = io ? sw_i : (model_mem.exists(idx) ? model_mem[idx] : 16'hxxxx);
        busy_end = (n == 3) ? 3 : n;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            mem_ena = (i < n);
            if (i == 0) begin
                addr       = a;
                mem_wr_ena = wr;
                wdata      = wd;
            end else begin
                addr       = 16'($urandom);
                mem_wr_ena = 1'($urandom);
                wdata      = 16'($urandom);
            end
            @(negedge clk);
            busy_exp  = (i >= 1) && (i <= busy_end);
            valid_exp = !wr && (n == 3) && (i == 2);
            err_exp   = err_m || ((n < 3) && (i > n));
            chk("busy", {15'b0, busy}, {15'b0, busy_exp});
            chk("rdata_valid", {15'b0, rdata_valid}, {15'b0, valid_exp});
            if (valid_exp)
                chk("rdata", rdata, rd_val);
            else
                chk("rdata_hold", rdata, last_rd);
            chk("err", {15'b0, err}, {15'b0, err_exp});
            chk("hex_o", hex_o, hex_m);
            if (i == 0 && wr) begin
                if (io) hex_m = wd;
                else    model_mem[idx] = wd;
            end
            if (valid_exp) last_rd = rd_val;
        end
        if (n < 3) err_m = 1'b1;
    endtask

    initial begin
        int unsigned tbl [8];
        logic [15:0] a;
        bit          wr;
        int          idx;

        tbl = '{10'h000, 10'h001, 10'h005, 10'h010, 10'h0A5, 10'h200, 10'h3FE, 10'h3FF};
        clk        = 1'b0;
        reset      = 1'b1;
        mem_ena    = 1'b0;
        mem_wr_ena = 1'b0;
        addr       = 16'h0000;
        wdata      = 16'h0000;
        sw_i       = 16'hBEEF;
        last_rd    = 16'h0000;
        hex_m      = HEX_RST;
        err_m      = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {15'b0, busy}, 16'h0000);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_valid", {15'b0, rdata_valid}, 16'h0000);
        chk("rst_err", {15'b0, err}, 16'h0000);
        chk("rst_hex", hex_o, HEX_RST);
        @(posedge clk);
        #1 reset = 1'b0;

        // Write then read
        access(16'h0010, 1'b1, 16'h1234, 3);
        access(16'h0010, 1'b0, 16'h0000, 3);

        // Back-to-back reads
        access(16'h0000, 1'b1, 16'hAAAA, 3);
        access(16'h0001, 1'b1, 16'h5555, 3);
        access(16'h0000, 1'b0, 16'h0000, 3);
        access(16'h0001, 1'b0, 16'h0000, 3);

        // xFFFF: I/O when mapped, alias of x03FF otherwise; plus upper-bit aliasing
        access(16'h03FF, 1'b1, 16'h1111, 3);
        access(16'h0405, 1'b1, 16'h7777, 3);
        access(16'h0005, 1'b0, 16'h0000, 3);
        access(16'hFFFF, 1'b0, 16'h0000, 3);
        access(16'hFFFF, 1'b1, 16'h00C3, 3);
        access(16'h03FF, 1'b0, 16'h0000, 3);
        access(16'hFFFF, 1'b0, 16'h0000, 3);

        // Random accesses over a small address set with random upper bits
        for (int k = 0; k < 40; k++) begin
            idx = int'(tbl[$urandom_range(0, 7)]);
            a   = {6'($urandom), 10'(idx)};
            wr  = 1'($urandom);
            if (!(MMIO && a == 16'hFFFF) && !model_mem.exists(idx)) wr = 1'b1;
            access(a, wr, 16'($urandom), 3);
        end

        // Protocol errors: short strobes, sticky err
        access(16'h0010, 1'b0, 16'h0000, 2);
        access(16'h0001, 1'b1, 16'hBBBB, 1);
        access(16'h0001, 1'b0, 16'h0000, 3);

        // Reset asserted in ACC1 of a read
        @(posedge clk);
        #1;
        mem_ena    = 1'b1;
        mem_wr_ena = 1'b0;
        addr       = 16'h0010;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        mem_ena = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {15'b0, busy}, 16'h0000);
        chk("mid_rst_rdata", rdata, 16'h0000);
        chk("mid_rst_valid", {15'b0, rdata_valid}, 16'h0000);
        chk("mid_rst_err", {15'b0, err}, 16'h0000);
        chk("mid_rst_hex", hex_o, HEX_RST);
        last_rd = 16'h0000;
        err_m   = 1'b0;
        hex_m   = HEX_RST;

        // BRAM contents survive reset
        access(16'h0001, 1'b0, 16'h0000, 3);
        access(16'h0010, 1'b0, 16'h0000, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
